// File: rtl/alu_cmd_sequencer_if.sv
// Command / ALU / result bundle for alu_cmd_sequencer.
// Both streams (in_* and res_*) use valid/ready: a transfer happens at the
// rising edge where valid and ready are both high. The sender holds its
// payload steady while valid is high and ready is low. Ready may be high
// while valid is low.
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int OPR_W  = 4,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [OPR_W-1:0]  in_opr;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  logic [OPR_W-1:0]  alu_opr;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_o;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [OPR_W-1:0]  res_opr;

  logic              illegal;
  logic [7:0]        err_cnt;
  logic [CNT_W-1:0]  fifo_cnt;

  // Debug view of the issue stage: 1 = EXEC, 0 = EMPTY.
  logic              dbg_exec;

  // Sequencer side.
  modport slave (
    input  in_valid, in_opr, in_a, in_b, alu_o, res_ready,
    output in_ready, alu_opr, alu_a, alu_b,
    output res_valid, res_data, res_opr,
    output illegal, err_cnt, fifo_cnt, dbg_exec
  );

  // Command source / ALU / result consumer side.
  modport master (
    output in_valid, in_opr, in_a, in_b, alu_o, res_ready,
    input  in_ready, alu_opr, alu_a, alu_b,
    input  res_valid, res_data, res_opr,
    input  illegal, err_cnt, fifo_cnt, dbg_exec
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequencer around a combinational ALU: a command FIFO, a registered issue
// stage that drives the ALU operands, and a result register with valid/ready.
// Reserved opcodes 10 and 11 are dropped at the FIFO head and counted.
module alu_cmd_sequencer #(
  parameter int DATA_W = 4,
  parameter int OPR_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [OPR_W-1:0] OPR_RSV0 = OPR_W'(10);
  localparam logic [OPR_W-1:0] OPR_RSV1 = OPR_W'(11);
  localparam logic [7:0]       ERR_MAX  = 8'hFF;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_EXEC  = 1'b1
  } issue_state_t;

  // FIFO storage and bookkeeping
  logic [OPR_W-1:0]  r_mem_opr [DEPTH];
  logic [DATA_W-1:0] r_mem_a   [DEPTH];
  logic [DATA_W-1:0] r_mem_b   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;

  // Issue stage
  issue_state_t      r_state;
  logic [OPR_W-1:0]  r_alu_opr;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              r_illegal;
  logic [7:0]        r_err_cnt;

  // Result register
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic [OPR_W-1:0]  r_res_opr;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_capture;
  logic              w_pop;
  logic [OPR_W-1:0]  w_head_opr;
  logic              w_head_rsv;

  // in_ready is plain !full: a pop at the same edge does not free a slot early.
  assign w_full     = (r_cnt == CNT_FULL);
  assign w_empty    = (r_cnt == '0);
  assign w_push     = bus.in_valid && !w_full;
  assign w_capture  = (r_state == S_EXEC) && (!r_res_valid || bus.res_ready);
  assign w_pop      = !w_empty && ((r_state == S_EMPTY) || w_capture);
  assign w_head_opr = r_mem_opr[r_rd_ptr];
  assign w_head_rsv = (w_head_opr == OPR_RSV0) || (w_head_opr == OPR_RSV1);

  // FIFO payload write; storage needs no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_opr[r_wr_ptr] <= bus.in_opr;
      r_mem_a[r_wr_ptr]   <= bus.in_a;
      r_mem_b[r_wr_ptr]   <= bus.in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_ONE;
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Issue FSM: load the popped head, or drop it if reserved; outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_alu_opr <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_illegal <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_illegal <= w_pop && w_head_rsv;
      if (w_pop && w_head_rsv && (r_err_cnt != ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_pop && !w_head_rsv) begin
            r_alu_opr <= w_head_opr;
            r_alu_a   <= r_mem_a[r_rd_ptr];
            r_alu_b   <= r_mem_b[r_rd_ptr];
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_pop && !w_head_rsv) begin
            r_alu_opr <= w_head_opr;
            r_alu_a   <= r_mem_a[r_rd_ptr];
            r_alu_b   <= r_mem_b[r_rd_ptr];
          end else if (w_capture) begin
            // Operands stay put so the ALU inputs do not toggle while idle.
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // Result register: capture from the ALU or let the consumer drain it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_opr   <= '0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_res_data  <= bus.alu_o;
      r_res_opr   <= r_alu_opr;
    end else if (r_res_valid && bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.alu_opr   = r_alu_opr;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_opr   = r_res_opr;
  assign bus.illegal   = r_illegal;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.fifo_cnt  = r_cnt;
  assign bus.dbg_exec  = (r_state == S_EXEC);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural 4-bit ALU.
module tb_alu_cmd_sequencer;
  logic clk;
  logic rst;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU on the far side of alu_opr/alu_a/alu_b.
  function automatic logic [3:0] alu_fn(input logic [3:0] opr, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (opr)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~a;
      4'd6:  r = a << 1;
      4'd7:  r = a >> 1;
      4'd8:  r = a + 4'd1;
      4'd9:  r = a - 4'd1;
      4'd12: r = ~(a & b);
      4'd13: r = ~(a | b);
      4'd14: r = ~(a ^ b);
      4'd15: r = b;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  function automatic bit is_rsv(input logic [3:0] opr);
    return (opr == 4'd10) || (opr == 4'd11);
  endfunction

  always_comb bus.alu_o = alu_fn(bus.alu_opr, bus.alu_a, bus.alu_b);

  // Scoreboard state
  logic [7:0] exp_q[$];
  int n_tests;
  int n_fail;
  int n_res;
  int n_ill;
  int max_cnt;
  int exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, describing the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready && !is_rsv(bus.in_opr)) begin
        exp_q.push_back({bus.in_opr, alu_fn(bus.in_opr, bus.in_a, bus.in_b)});
      end
      if (bus.res_valid && bus.res_ready) begin
        n_res++;
        if (exp_q.size() == 0) check("sb_unexpected_result", {bus.res_opr, bus.res_data}, 32'hFFFF);
        else check("sb_result", {bus.res_opr, bus.res_data}, exp_q.pop_front());
      end
      if (bus.illegal) n_ill++;
      if (bus.dbg_exec) check("no_reserved_issue", 32'(is_rsv(bus.alu_opr)), 32'd0);
      if (int'(bus.fifo_cnt) > max_cnt) max_cnt = int'(bus.fifo_cnt);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] opr, input logic [3:0] a, input logic [3:0] b);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_opr   = opr;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    repeat (8) step();
  endtask

  typedef struct {
    logic [3:0] opr;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_o;
    bit         drop;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int r0;
    int i0;
    vecs[0]  = '{4'd0,  4'd3,  4'd2,  4'd5,  1'b0};
    vecs[1]  = '{4'd1,  4'd3,  4'd5,  4'd14, 1'b0};
    vecs[2]  = '{4'd2,  4'd12, 4'd10, 4'd8,  1'b0};
    vecs[3]  = '{4'd4,  4'd15, 4'd5,  4'd10, 1'b0};
    vecs[4]  = '{4'd6,  4'd9,  4'd0,  4'd2,  1'b0};
    vecs[5]  = '{4'd7,  4'd9,  4'd0,  4'd4,  1'b0};
    vecs[6]  = '{4'd9,  4'd0,  4'd0,  4'd15, 1'b0};
    vecs[7]  = '{4'd10, 4'd1,  4'd1,  4'd0,  1'b1};
    vecs[8]  = '{4'd13, 4'd5,  4'd3,  4'd8,  1'b0};
    vecs[9]  = '{4'd11, 4'd2,  4'd2,  4'd0,  1'b1};
    vecs[10] = '{4'd15, 4'd1,  4'd7,  4'd7,  1'b0};
    vecs[11] = '{4'd14, 4'd6,  4'd6,  4'd15, 1'b0};

    n_tests = 0; n_fail = 0; n_res = 0; n_ill = 0; max_cnt = 0; exp_err = 0;
    bus.in_valid = 1'b0; bus.in_opr = '0; bus.in_a = '0; bus.in_b = '0;
    bus.res_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) step();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_fifo_cnt", bus.fifo_cnt, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_alu", {bus.alu_opr, bus.alu_a, bus.alu_b}, 0);
    check("rst_err_illegal", {bus.err_cnt, bus.illegal}, 0);
    rst = 1'b0;
    bus.res_ready = 1'b1;
    step();

    // Single commands: issue one cycle after accept, result one cycle later.
    for (int i = 0; i < 12; i++) begin
      bus.in_opr = vecs[i].opr; bus.in_a = vecs[i].a; bus.in_b = vecs[i].b;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("vec_fifo_cnt_after_push", bus.fifo_cnt, 1);
      step();
      if (vecs[i].drop) begin
        exp_err++;
        check("vec_illegal_pulse", bus.illegal, 1);
        check("vec_err_cnt", bus.err_cnt, exp_err);
        check("vec_drop_not_exec", bus.dbg_exec, 0);
      end else begin
        check("vec_alu_issue", {bus.alu_opr, bus.alu_a, bus.alu_b}, {vecs[i].opr, vecs[i].a, vecs[i].b});
        check("vec_exec", bus.dbg_exec, 1);
        check("vec_no_illegal", bus.illegal, 0);
      end
      step();
      if (vecs[i].drop) begin
        check("vec_drop_no_result", bus.res_valid, 0);
        check("vec_illegal_one_cycle", bus.illegal, 0);
      end else begin
        check("vec_res_valid", bus.res_valid, 1);
        check("vec_res_data", bus.res_data, vecs[i].exp_o);
        check("vec_res_opr", bus.res_opr, vecs[i].opr);
      end
      step();
    end
    drain();

    // Back-to-back stream of all legal opcodes: one result per cycle.
    r0 = n_res; i0 = n_ill;
    for (int k = 0; k < 14; k++) begin
      bus.in_opr = (k < 10) ? 4'(k) : 4'(k + 2);
      bus.in_a = 4'd3; bus.in_b = 4'd2;
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    check("stream_results_during_fill", n_res - r0, 11);
    repeat (3) step();
    check("stream_results_total", n_res - r0, 14);
    check("stream_no_illegal", n_ill - i0, 0);
    check("stream_err_cnt", bus.err_cnt, exp_err);
    drain();

    // Reserved opcodes interleaved with legal ones.
    r0 = n_res; i0 = n_ill;
    push_cmd(4'd9, 4'd5, 4'd3);
    push_cmd(4'd10, 4'd5, 4'd3);
    push_cmd(4'd11, 4'd5, 4'd3);
    push_cmd(4'd12, 4'd5, 4'd3);
    drain();
    exp_err += 2;
    check("rsv_results", n_res - r0, 2);
    check("rsv_illegal_pulses", n_ill - i0, 2);
    check("rsv_err_cnt", bus.err_cnt, exp_err);

    // err_cnt saturation with a long run of reserved opcodes.
    for (int k = 0; k < 300; k++) push_cmd((k % 2 == 0) ? 4'd10 : 4'd11, 4'(k), 4'd0);
    drain();
    check("err_cnt_saturated", bus.err_cnt, 255);
    i0 = n_ill;
    push_cmd(4'd11, 4'd0, 4'd0);
    drain();
    check("err_cnt_stays_255", bus.err_cnt, 255);
    check("illegal_after_saturation", n_ill - i0, 1);

    // Back-pressure: fill result, issue stage and FIFO, then hold a 7th command.
    bus.res_ready = 1'b0;
    push_cmd(4'd0, 4'd1, 4'd6);
    for (int k = 1; k < 6; k++) push_cmd(4'(k), 4'(k + 3), 4'(7 - k));
    bus.in_opr = 4'd8; bus.in_a = 4'd12; bus.in_b = 4'd0;
    bus.in_valid = 1'b1;
    repeat (2) step();
    check("bp_fifo_full", bus.fifo_cnt, 4);
    check("bp_in_ready_low", bus.in_ready, 0);
    check("bp_res_held", {bus.res_valid, bus.res_opr, bus.res_data}, {1'b1, 4'd0, 4'd7});
    check("bp_exec_held", {bus.dbg_exec, bus.alu_opr}, {1'b1, 4'd1});
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("full_refuse_with_pop", bus.in_ready, 0);
    @(posedge clk); #1;
    check("full_pop_only", bus.fifo_cnt, 3);
    check("full_ready_next", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("push_pop_same_edge", bus.fifo_cnt, 3);
    drain();

    // Mid-operation reset flushes FIFO, issue stage and result register.
    bus.res_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_cmd(4'(k + 2), 4'(k), 4'd1);
    check("pre_rst_fifo_cnt", bus.fifo_cnt, 3);
    check("pre_rst_exec_res", {bus.dbg_exec, bus.res_valid}, 2'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_err = 0;
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_fifo_cnt", bus.fifo_cnt, 0);
    check("post_rst_res", {bus.res_valid, bus.res_opr, bus.res_data}, 0);
    check("post_rst_alu", {bus.alu_opr, bus.alu_a, bus.alu_b, bus.dbg_exec}, 0);
    check("post_rst_err", {bus.err_cnt, bus.illegal}, 0);
    r0 = n_res;
    bus.res_ready = 1'b1;
    push_cmd(4'd3, 4'd12, 4'd3);
    push_cmd(4'd8, 4'd15, 4'd0);
    drain();
    check("post_rst_results", n_res - r0, 2);

    check("max_fifo_cnt", max_cnt, 4);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
